// File: rtl/demux1_4_stream_pkg.sv
// demux_pkg -- definitions shared by the 1:4 stream demultiplexer.
//   state_t      : buffer occupancy (EMPTY / FULL)
//   CH_A..CH_D   : channel indices, also the bit positions in valid/ready
//   NUM_CH       : number of output channels
package demux_pkg;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic [1:0] CH_A = 2'd0;
  localparam logic [1:0] CH_B = 2'd1;
  localparam logic [1:0] CH_C = 2'd2;
  localparam logic [1:0] CH_D = 2'd3;

  localparam int NUM_CH = 4;

endpackage

// File: rtl/demux1_4_stream_rr_ptr2.sv
// rr_ptr2 -- 2-bit wrapping round-robin pointer.
//   clk : rising-edge clock
//   rst : synchronous active-high reset, pointer -> 00
//   en  : advance the pointer by one (11 wraps to 00)
//   ptr : current pointer value
module rr_ptr2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [1:0] ptr
);

  logic [1:0] ptr_q;
  logic [1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (en) begin
      // natural 2-bit overflow gives the 11 -> 00 wrap
      ptr_d = ptr_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 2'd0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/demux1_4_stream.sv
// demux1_4_stream -- one-entry buffered 1:4 stream demultiplexer.
// A word accepted on the input handshake is held in a single buffer and
// presented on exactly one output channel, chosen at accept time either by
// sel or by a round-robin pointer.
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset
//   in         : input data word
//   in_valid   : source offers a word
//   in_ready   : block can accept a word (combinational)
//   sel        : destination when rr=0 (00=A .. 11=D)
//   rr         : 1 = use round-robin pointer instead of sel
//   A, B, C, D : channel data, zero when the channel is not valid
//   valid      : per-channel valid, bit0=A .. bit3=D
//   ready      : per-channel sink ready, bit0=A .. bit3=D
module demux1_4_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       sel,
  input  logic             rr,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] D,
  output logic [3:0]       valid,
  input  logic [3:0]       ready
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [1:0]       dest_q, dest_d;

  logic [1:0]       rr_ptr;
  logic             accept;
  logic             transfer;
  logic             dest_ready;
  logic             out_active;
  logic [1:0]       acc_dest;

  logic [NUM_CH-1:0] ch_valid;
  logic [WIDTH-1:0]  ch_data [NUM_CH];

  // Only the held destination's ready bit matters; others are ignored.
  assign dest_ready = ready[dest_q];

  // Outputs are suppressed while rst is high so no sink can complete a
  // transfer on the edge that discards the buffer.
  assign out_active = (state_q == FULL) && !rst;
  assign transfer   = out_active && dest_ready;

  // A FULL buffer can take a new word in the same cycle it is drained.
  assign in_ready = !rst && ((state_q == EMPTY) || dest_ready);
  assign accept   = in_valid && in_ready;
  assign acc_dest = rr ? rr_ptr : sel;

  rr_ptr2 u_rr_ptr2 (
    .clk (clk),
    .rst (rst),
    .en  (accept && rr),
    .ptr (rr_ptr)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    dest_d  = dest_q;
    if (accept) begin
      // covers both EMPTY->FULL and drain-and-refill, which stays FULL
      state_d = FULL;
      data_d  = in;
      dest_d  = acc_dest;
    end else if (transfer) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      dest_q  <= CH_A;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      dest_q  <= dest_d;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign ch_valid[gi] = out_active && (dest_q == 2'(gi));
      assign ch_data[gi]  = ch_valid[gi] ? data_q : '0;
    end
  endgenerate

  assign valid = ch_valid;
  assign A     = ch_data[CH_A];
  assign B     = ch_data[CH_B];
  assign C     = ch_data[CH_C];
  assign D     = ch_data[CH_D];

endmodule

// File: tb/tb_demux1_4_stream.sv
// Testbench for demux1_4_stream: table-driven directed vectors plus a short
// hand-written hold sequence. Inputs change 1ns after the rising edge and
// outputs are compared on the falling edge.
module tb_demux1_4_stream;

  logic       clk;
  logic       rst;
  logic [3:0] din;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] sel;
  logic       rr;
  logic [3:0] a_o, b_o, c_o, d_o;
  logic [3:0] valid;
  logic [3:0] ready;

  int checks;
  int errors;

  demux1_4_stream #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in       (din),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sel      (sel),
    .rr       (rr),
    .A        (a_o),
    .B        (b_o),
    .C        (c_o),
    .D        (d_o),
    .valid    (valid),
    .ready    (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       iv;
    logic [3:0] din;
    logic [1:0] sel;
    logic       rr;
    logic [3:0] rdy;
    logic [3:0] ev;
    logic [3:0] ea, eb, ec, ed;
    logic       eir;
  } vec_t;

  localparam int NV = 33;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic r, input logic iv, input logic [3:0] d,
                              input logic [1:0] s, input logic m, input logic [3:0] rd,
                              input logic [3:0] ev, input logic [3:0] ea,
                              input logic [3:0] eb, input logic [3:0] ec,
                              input logic [3:0] ed, input logic eir);
    vec_t v;
    v.rst = r; v.iv = iv; v.din = d; v.sel = s; v.rr = m; v.rdy = rd;
    v.ev = ev; v.ea = ea; v.eb = eb; v.ec = ec; v.ed = ed; v.eir = eir;
    return v;
  endfunction

  task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [3:0] ev, input logic [3:0] ea,
                            input logic [3:0] eb, input logic [3:0] ec,
                            input logic [3:0] ed, input logic eir);
    check4({tag, ".valid"}, valid, ev);
    check4({tag, ".A"}, a_o, ea);
    check4({tag, ".B"}, b_o, eb);
    check4({tag, ".C"}, c_o, ec);
    check4({tag, ".D"}, d_o, ed);
    check4({tag, ".in_ready"}, {3'b000, in_ready}, {3'b000, eir});
  endtask

  initial begin
    checks = 0;
    errors = 0;

    //               rst iv din  sel   rr rdy      ev       A  B  C  D  ir
    // back-to-back sel routing, one word per cycle
    tbl[0]  = mk(0, 1, 4,  2'd0, 0, 4'b1111, 4'b0000, 0, 0, 0, 0, 1);
    tbl[1]  = mk(0, 1, 5,  2'd1, 0, 4'b1111, 4'b0001, 4, 0, 0, 0, 1);
    tbl[2]  = mk(0, 1, 8,  2'd2, 0, 4'b1111, 4'b0010, 0, 5, 0, 0, 1);
    tbl[3]  = mk(0, 1, 15, 2'd3, 0, 4'b1111, 4'b0100, 0, 0, 8, 0, 1);
    tbl[4]  = mk(0, 0, 0,  2'd0, 0, 4'b1111, 4'b1000, 0, 0, 0, 15, 1);
    tbl[5]  = mk(0, 0, 0,  2'd0, 0, 4'b1111, 4'b0000, 0, 0, 0, 0, 1);
    // backpressure on B; other ready bits ignored
    tbl[6]  = mk(0, 1, 5,  2'd1, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 1);
    tbl[7]  = mk(0, 0, 0,  2'd0, 0, 4'b0000, 4'b0010, 0, 5, 0, 0, 0);
    tbl[8]  = mk(0, 0, 0,  2'd2, 0, 4'b1101, 4'b0010, 0, 5, 0, 0, 0);
    tbl[9]  = mk(0, 0, 0,  2'd0, 0, 4'b0010, 4'b0010, 0, 5, 0, 0, 1);
    tbl[10] = mk(0, 0, 0,  2'd0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 1);
    // round-robin with sel scrambled, pointer wraps
    tbl[11] = mk(0, 1, 4,  2'd3, 1, 4'b1111, 4'b0000, 0, 0, 0, 0, 1);
    tbl[12] = mk(0, 1, 5,  2'd1, 1, 4'b1111, 4'b0001, 4, 0, 0, 0, 1);
    tbl[13] = mk(0, 1, 8,  2'd0, 1, 4'b1111, 4'b0010, 0, 5, 0, 0, 1);
    tbl[14] = mk(0, 1, 15, 2'd2, 1, 4'b1111, 4'b0100, 0, 0, 8, 0, 1);
    tbl[15] = mk(0, 1, 4,  2'd1, 1, 4'b1111, 4'b1000, 0, 0, 0, 15, 1);
    tbl[16] = mk(0, 0, 0,  2'd3, 1, 4'b1111, 4'b0001, 4, 0, 0, 0, 1);
    tbl[17] = mk(0, 0, 0,  2'd0, 0, 4'b1111, 4'b0000, 0, 0, 0, 0, 1);
    // drain C and refill to D in the same cycle
    tbl[18] = mk(0, 1, 8,  2'd2, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 1);
    tbl[19] = mk(0, 1, 15, 2'd3, 0, 4'b0100, 4'b0100, 0, 0, 8, 0, 1);
    tbl[20] = mk(0, 0, 0,  2'd0, 0, 4'b0000, 4'b1000, 0, 0, 0, 15, 0);
    tbl[21] = mk(0, 0, 0,  2'd0, 0, 4'b1000, 4'b1000, 0, 0, 0, 15, 1);
    tbl[22] = mk(0, 0, 0,  2'd0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 1);
    // reset while FULL on D
    tbl[23] = mk(0, 1, 15, 2'd3, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 1);
    tbl[24] = mk(0, 0, 0,  2'd0, 0, 4'b0000, 4'b1000, 0, 0, 0, 15, 0);
    tbl[25] = mk(1, 0, 0,  2'd0, 0, 4'b1000, 4'b0000, 0, 0, 0, 0, 0);
    tbl[26] = mk(0, 0, 0,  2'd0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 1);
    // pointer restarts at 00, survives an rr=0 accept
    tbl[27] = mk(0, 1, 4,  2'd2, 1, 4'b1111, 4'b0000, 0, 0, 0, 0, 1);
    tbl[28] = mk(0, 1, 5,  2'd3, 1, 4'b1111, 4'b0001, 4, 0, 0, 0, 1);
    tbl[29] = mk(0, 1, 8,  2'd0, 0, 4'b1111, 4'b0010, 0, 5, 0, 0, 1);
    tbl[30] = mk(0, 1, 15, 2'd0, 1, 4'b1111, 4'b0001, 8, 0, 0, 0, 1);
    tbl[31] = mk(0, 0, 0,  2'd0, 0, 4'b1111, 4'b0100, 0, 0, 15, 0, 1);
    tbl[32] = mk(0, 0, 0,  2'd0, 0, 4'b1111, 4'b0000, 0, 0, 0, 0, 1);

    // initial reset
    rst = 1'b1; in_valid = 1'b0; din = '0; sel = '0; rr = 1'b0; ready = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outs("reset", 4'b0000, 0, 0, 0, 0, 1'b0);
    $display("reset: valid=%b in_ready=%b", valid, in_ready);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      rst      = tbl[i].rst;
      in_valid = tbl[i].iv;
      din      = tbl[i].din;
      sel      = tbl[i].sel;
      rr       = tbl[i].rr;
      ready    = tbl[i].rdy;
      @(negedge clk);
      $display("vec %0d: rst=%b iv=%b in=%0d sel=%0d rr=%b rdy=%b -> valid=%b A=%0d B=%0d C=%0d D=%0d in_ready=%b",
               i, rst, in_valid, din, sel, rr, ready, valid, a_o, b_o, c_o, d_o, in_ready);
      check_outs($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ea, tbl[i].eb,
                 tbl[i].ec, tbl[i].ed, tbl[i].eir);
      @(posedge clk);
      #1;
    end

    // hold on A under backpressure while sel/rr wander and non-A sinks are ready
    in_valid = 1'b1; din = 4'd9; sel = 2'd0; rr = 1'b0; ready = 4'b0000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sel   = 2'($urandom_range(0, 3));
      rr    = 1'($urandom_range(0, 1));
      ready = 4'b1110;
      @(negedge clk);
      $display("hold %0d: sel=%0d rr=%b rdy=%b -> valid=%b A=%0d in_ready=%b",
               k, sel, rr, ready, valid, a_o, in_ready);
      check_outs($sformatf("hold%0d", k), 4'b0001, 9, 0, 0, 0, 1'b0);
      @(posedge clk);
      #1;
    end
    ready = 4'b0001;
    @(negedge clk);
    check_outs("release", 4'b0001, 9, 0, 0, 0, 1'b1);
    @(posedge clk);
    #1;
    ready = 4'b0000;
    @(negedge clk);
    $display("drained: valid=%b in_ready=%b", valid, in_ready);
    check_outs("drained", 4'b0000, 0, 0, 0, 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
